rr_reg_arbiter: RTL
===================

Name: rr_reg_arbiter

Overview:
- Round-robin write arbiter that shares one DATA_W-bit register bank between N_REQ requesters.
- Each requester presents req plus write data. The arbiter picks one requester, grants it, loads its data into the shared register and acknowledges it.
- Sits between the lab's requester modules and the shared flip-flop register bank. It is the only writer of that bank.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of the shared register and of each write-data slice.
- IDX_W, $clog2(N_REQ), width of the requester index (derived, not overridden).

Ports:
- clk  input  1  single clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- req  input  N_REQ  request lines, one per requester; held high until ack.
- wdata  input  N_REQ*DATA_W  flattened write data; slice i = wdata[i*DATA_W +: DATA_W]; held stable while req[i] is high.
- gnt  output  N_REQ  registered one-hot grant; all zero when no grant.
- ack  output  N_REQ  registered one-cycle write-done pulse to the winner.
- q  output  DATA_W  shared register contents.
- q_owner  output  IDX_W  index of the last requester that wrote q.
- busy  output  1  high in GRANT and DONE.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high on port reset; no asynchronous reset anywhere.
- Reset values: state=IDLE, q=0, q_owner=0, gnt=0, ack=0, busy=0, priority pointer ptr=0.
- Reset asserted mid-transfer aborts it: no ack, q is cleared.
- FSM states: IDLE, GRANT, DONE.
- IDLE:
  - If any req bit is high, pick the winner w = first set bit searching ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1 (wrap-around).
  - Register w, set gnt=onehot(w), busy=1, go to GRANT.
  - Otherwise stay in IDLE with all outputs held.
- GRANT (one cycle):
  - If req[w]=1: q<=wdata slice w, q_owner<=w, ack<=onehot(w), gnt<=0, ptr<=(w+1) mod N_REQ, go to DONE.
  - If req[w]=0 (requester withdrew): abort. gnt<=0, busy<=0, q unchanged, no ack, ptr unchanged, go to IDLE.
- DONE (one cycle):
  - ack is high, q already holds the new value.
  - Next edge: ack<=0, busy<=0, go to IDLE.
  - DONE never arbitrates, because the winner's req is still high when DONE ends; arbitrating there would re-grant a stale request.
- Latency and throughput:
  - req seen at edge k → gnt visible after edge k → q and ack visible after edge k+1 → ack drops at edge k+2.
  - Earliest next arbitration is edge k+3, so one write per 3 cycles.
- Requester rule: drop req on the edge after sampling ack=1. If req is still high at the IDLE edge, the request is re-served, as a new request.
- Fairness: with all requesters requesting continuously, grants rotate 0,1,2,3,0,...; no requester waits more than N_REQ transfers.
- Requests that arrive while busy are not lost; they are evaluated at the next IDLE edge.
- gnt is one-hot or zero at all times; ack is never high in the same cycle as gnt.
- Pointer arithmetic wraps mod N_REQ. When N_REQ is not a power of two, ptr=N_REQ-1 advances to 0, never to N_REQ.

Decomposition:
- Shared package/header: state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_DONE=2'd2; default DATA_W and N_REQ constants.
- One natural sub-module: rr_pick. It is combinational: inputs req and ptr, outputs a found flag and winner index w.
- The top level holds the FSM, ptr, and the q/q_owner register bank.

Test Plan:
- Reset: assert reset for 2 cycles with req=4'b1111 → q=0, gnt=0, ack=0, busy=0, q_owner=0 throughout and on the first cycle after release.
- Single write: req=4'b0100, slice 2=8'hA5 → gnt=4'b0100 for 1 cycle; next cycle ack=4'b0100, q=8'hA5, q_owner=2; ptr becomes 3.
- Rotation: hold req=4'b1111, slices 0..3 = 8'h10,11,12,13, each requester dropping req after its ack and reasserting after 2 cycles → acks in order 0,1,2,3,0; q sequence 10,11,12,13,10; 3 cycles per transfer.
- Wrap-around: with ptr=3, req=4'b0011 → requester 0 is granted first, then 1.
- Withdrawal: req=4'b0010, drop req[1] during GRANT → no ack, q unchanged, ptr unchanged, busy low the next cycle.
- Reset mid-op: assert reset in the GRANT cycle with q=8'h3C → no ack, q=0 and state IDLE after the edge.

Source files
------------

// File: rtl/rr_reg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_reg_arbiter_pkg
// Shared definitions for the round-robin register-write arbiter:
//   - state_t          : FSM state encoding (IDLE / GRANT / DONE)
//   - DEF_N_REQ        : default number of requesters
//   - DEF_DATA_W       : default width of the shared register
// -----------------------------------------------------------------------------
package rr_reg_arbiter_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : rr_reg_arbiter_pkg

// File: rtl/rr_reg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search. Finds the first set request bit
// starting at i_ptr and wrapping past N_REQ-1 back to 0.
// Ports:
//   i_req   [N_REQ-1:0]  request lines
//   i_ptr   [IDX_W-1:0]  highest-priority index for this search
//   o_found              at least one request is set
//   o_w     [IDX_W-1:0]  winner index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_pick
  import rr_reg_arbiter_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_w
);

  // Rotating a doubled copy right by ptr puts request ptr at bit 0,
  // ptr+1 at bit 1, ... so a plain lowest-bit-first search gives the
  // round-robin order without any modulo on the request index.
  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_shift;
  logic [N_REQ-1:0]   w_rot;

  assign w_dbl   = {i_req, i_req};
  assign w_shift = w_dbl >> i_ptr;
  assign w_rot   = w_shift[N_REQ-1:0];

  always_comb begin
    int sum;
    // NOTE: every variable written in a combinational block gets a default
    // before any conditional assignment, otherwise a latch is inferred.
    o_found = 1'b0;
    o_w     = '0;
    sum     = 0;
    // Walk from the far end down so the offset nearest ptr is written last.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_found = 1'b1;
        sum     = int'(i_ptr) + j;
        if (sum >= N_REQ) begin
          sum = sum - N_REQ;
        end
        o_w = IDX_W'(sum);
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// rr_reg_arbiter
// Round-robin write arbiter in front of one shared DATA_W-bit register. A
// transfer takes three cycles: IDLE picks a winner and raises gnt, GRANT
// loads the winner's data and raises ack, DONE lets the requester see ack
// before the next arbitration.
// Ports:
//   clk                    clock, all state changes on the rising edge
//   reset                  synchronous active-high reset
//   req     [N_REQ-1:0]    request lines, held high until ack
//   wdata   [N_REQ*DATA_W] flattened write data, slice i for requester i
//   gnt     [N_REQ-1:0]    registered one-hot grant (zero when idle)
//   ack     [N_REQ-1:0]    registered one-cycle write-done pulse
//   q       [DATA_W-1:0]   shared register contents
//   q_owner [IDX_W-1:0]    index of the requester that last wrote q
//   busy                   high in GRANT and DONE
// -----------------------------------------------------------------------------
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter  int N_REQ  = DEF_N_REQ,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       q,
  output logic [IDX_W-1:0]        q_owner,
  output logic                    busy
);

  state_t              r_state,  w_state_nxt;
  logic [IDX_W-1:0]    r_ptr,    w_ptr_nxt;
  logic [IDX_W-1:0]    r_w,      w_w_nxt;
  logic [N_REQ-1:0]    r_gnt,    w_gnt_nxt;
  logic [N_REQ-1:0]    r_ack,    w_ack_nxt;
  logic [DATA_W-1:0]   r_q,      w_q_nxt;
  logic [IDX_W-1:0]    r_owner,  w_owner_nxt;
  logic                r_busy,   w_busy_nxt;

  logic                w_found;
  logic [IDX_W-1:0]    w_pick;
  logic [N_REQ-1:0]    w_pick_onehot;
  logic [N_REQ-1:0]    w_held_onehot;
  logic [DATA_W-1:0]   w_slice;
  logic [IDX_W-1:0]    w_ptr_inc;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_w     (w_pick)
  );

  // One-hot decodes and the winner's data slice, selected by index compare
  // so no variable-width arithmetic appears in a part-select.
  always_comb begin
    w_pick_onehot = '0;
    w_held_onehot = '0;
    w_slice       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pick_onehot[i] = (w_pick == IDX_W'(i));
      w_held_onehot[i] = (r_w == IDX_W'(i));
      if (r_w == IDX_W'(i)) begin
        w_slice = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Explicit wrap so a non-power-of-two N_REQ never lets ptr reach N_REQ.
  assign w_ptr_inc = (r_w == IDX_W'(N_REQ - 1)) ? '0 : r_w + IDX_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_w_nxt     = r_w;
    w_gnt_nxt   = r_gnt;
    w_ack_nxt   = r_ack;
    w_q_nxt     = r_q;
    w_owner_nxt = r_owner;
    w_busy_nxt  = r_busy;

    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_w_nxt     = w_pick;
          w_gnt_nxt   = w_pick_onehot;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_GRANT;
        end
      end

      ST_GRANT: begin
        w_gnt_nxt = '0;
        if (req[r_w]) begin
          w_q_nxt     = w_slice;
          w_owner_nxt = r_w;
          w_ack_nxt   = w_held_onehot;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = ST_DONE;
        end else begin
          // Requester withdrew: drop the grant, leave q and ptr untouched.
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_DONE: begin
        // No arbitration here: the winner's req is still high this cycle
        // and would be re-granted as a stale request.
        w_ack_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_w     <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_q     <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_w     <= w_w_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_q     <= w_q_nxt;
      r_owner <= w_owner_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign ack     = r_ack;
  assign q       = r_q;
  assign q_owner = r_owner;
  assign busy    = r_busy;

endmodule : rr_reg_arbiter
